// File: rtl/data_memory_port_if.sv
// Request/response bus between the load/store stage and data_memory_port.
// The master issues sized load/store requests and consumes responses.
// The slave (the memory port) accepts requests and returns responses.
interface data_memory_port_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_memory_port.sv
// data_memory_port: byte-addressed, big-endian data memory behind a valid/ready
// request/response port. Sized loads (sign/zero-extended) and sized stores;
// accesses crossing a word boundary are split into two word beats.
// Storage is a word array with a registered read so it maps onto block RAM.
// Build option: define MEM_MISALIGN_TRAP_EN to reject any access that is not
// naturally aligned instead of splitting it (the second beat is then removed).
module data_memory_port #(
  parameter int DEPTH_BYTES = 4096,
  parameter int ADDR_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  data_memory_port_if.slave bus
);

  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int LOW_W = IDX_W + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Number of bytes covered by a size code (reserved code treated as a word).
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      2'd0:    size_bytes = 3'd1;
      2'd1:    size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

  // Right-shift that moves a top-aligned value of this size down to bit 0.
  function automatic logic [4:0] size_pad_shift(input logic [1:0] size);
    case (size)
      2'd0:    size_pad_shift = 5'd24;
      2'd1:    size_pad_shift = 5'd16;
      default: size_pad_shift = 5'd0;
    endcase
  endfunction

  // Byte-lane mask for an access of this size starting at lane offset 0.
  function automatic logic [3:0] size_lane_mask(input logic [1:0] size);
    case (size)
      2'd0:    size_lane_mask = 4'b1000;
      2'd1:    size_lane_mask = 4'b1100;
      default: size_lane_mask = 4'b1111;
    endcase
  endfunction

  // Request rejection: reserved size, or last byte beyond the array. The end
  // address is formed one bit wider than the address so it cannot wrap.
  function automatic logic access_err(input logic [ADDR_W-1:0] addr,
                                      input logic [1:0]        size);
    logic [ADDR_W:0] span;
    logic [ADDR_W:0] last;
    logic            bad;
    span      = '0;
    span[2:0] = size_bytes(size);
    last      = {1'b0, addr} + span - {{ADDR_W{1'b0}}, 1'b1};
    bad       = (size == 2'd3) || (last >= (ADDR_W+1)'(DEPTH_BYTES));
`ifdef MEM_MISALIGN_TRAP_EN
    if ((size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00))
      bad = 1'b1;
`endif
    access_err = bad;
  endfunction

  // Sign- or zero-extension of the right-aligned load value.
  function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                              input logic [1:0]  size,
                                              input logic        uns);
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] ext_s;
    b_s = raw[7:0];
    h_s = raw[15:0];
    case (size)
      2'd0: begin
        ext_s = b_s;
        extend_load = uns ? {24'h0, raw[7:0]} : ext_s;
      end
      2'd1: begin
        ext_s = h_s;
        extend_load = uns ? {16'h0, raw[15:0]} : ext_s;
      end
      default: extend_load = raw;
    endcase
  endfunction

  logic             accept;
  logic             req_err;
  logic             req_split;

  logic             we_p0;
  logic             uns_p0;
  logic             err_p0;
  logic             split_p0;
  logic [1:0]       size_p0;
  logic [LOW_W-1:0] addr_p0;
  logic [31:0]      wdata_p0;

  logic [31:0]      mem [WORDS];
  logic [31:0]      rd_p1;
`ifndef MEM_MISALIGN_TRAP_EN
  logic [31:0]      hi_p1;
`endif

  logic [1:0]       off_p0;
  logic [4:0]       sh_off;
  logic [4:0]       sh_pad;
  logic [63:0]      wwin;
  logic [7:0]       be8;
  logic [63:0]      rwin;
  logic [63:0]      rwin_sh;
  logic [31:0]      load_raw;
  logic [31:0]      load_val;

  logic             ram_en;
  logic [IDX_W-1:0] ram_idx;
  logic [31:0]      ram_wd;
  logic [3:0]       ram_be;

  assign accept  = bus.req_valid && bus.req_ready;
  assign req_err = access_err(bus.req_addr, bus.req_size);
`ifdef MEM_MISALIGN_TRAP_EN
  assign req_split = 1'b0;
`else
  assign req_split = ({1'b0, bus.req_addr[1:0]} + size_bytes(bus.req_size)) > 3'd4;
`endif

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and port outputs.
  always_comb begin
    state_nxt     = state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_err   = 1'b0;
    bus.rsp_rdata = 32'h0;
    case (state)
      IDLE: begin
        bus.req_ready = rst_n;
        if (accept) state_nxt = req_err ? RESP : BEAT0;
      end
      BEAT0: begin
`ifdef MEM_MISALIGN_TRAP_EN
        state_nxt = RESP;
`else
        state_nxt = split_p0 ? BEAT1 : RESP;
`endif
      end
      BEAT1: begin
        state_nxt = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = err_p0;
        bus.rsp_rdata = (err_p0 || we_p0) ? 32'h0 : load_val;
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture: all fields held for the life of the access.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= bus.req_we;
      uns_p0   <= bus.req_unsigned;
      size_p0  <= bus.req_size;
      addr_p0  <= bus.req_addr[LOW_W-1:0];
      wdata_p0 <= bus.req_wdata;
      err_p0   <= req_err;
      split_p0 <= req_split;
    end
  end

  // Store data and lane enables laid out over a two-word window, first word
  // in the upper half; big-endian so offset 0 is the most significant lane.
  always_comb begin
    off_p0 = addr_p0[1:0];
    sh_off = {off_p0, 3'b000};
    sh_pad = size_pad_shift(size_p0);
    wwin   = {(wdata_p0 << sh_pad), 32'h0} >> sh_off;
    be8    = {size_lane_mask(size_p0), 4'b0000} >> off_p0;
  end

  // Word-beat selection of RAM index, write data and lane enables.
  always_comb begin
    ram_en  = 1'b0;
    ram_idx = addr_p0[LOW_W-1:2];
    ram_wd  = wwin[63:32];
    ram_be  = be8[7:4];
    case (state)
      BEAT0: ram_en = rst_n;
`ifndef MEM_MISALIGN_TRAP_EN
      BEAT1: begin
        ram_en  = rst_n;
        ram_idx = addr_p0[LOW_W-1:2] + {{(IDX_W-1){1'b0}}, 1'b1};
        ram_wd  = wwin[31:0];
        ram_be  = be8[3:0];
      end
`endif
      default: ram_en = 1'b0;
    endcase
  end

  // Word RAM: per-lane writes, registered read held while idle.
  always_ff @(posedge clk) begin
    if (ram_en) begin
      if (we_p0) begin
        for (int j = 0; j < 4; j++) begin
          if (ram_be[j]) mem[ram_idx][8*j +: 8] <= ram_wd[8*j +: 8];
        end
      end else begin
        rd_p1 <= mem[ram_idx];
      end
    end
  end

`ifndef MEM_MISALIGN_TRAP_EN
  // Keep the first beat's read word while the second beat reloads the RAM output.
  always_ff @(posedge clk) begin
    if (state == BEAT1) hi_p1 <= rd_p1;
  end
`endif

  // Load assembly: bytes in address order, right-aligned, then extended.
  always_comb begin
`ifdef MEM_MISALIGN_TRAP_EN
    rwin = {rd_p1, 32'h0};
`else
    rwin = split_p0 ? {hi_p1, rd_p1} : {rd_p1, 32'h0};
`endif
    rwin_sh  = rwin << sh_off;
    load_raw = rwin_sh[63:32] >> sh_pad;
    load_val = extend_load(load_raw, size_p0, uns_p0);
  end

endmodule

// File: tb/tb_data_memory_port.sv
// Self-checking bench for data_memory_port: a byte-level reference model
// produces expected responses, queued at request time and compared when the
// port responds.
module tb_data_memory_port;

  localparam int DEPTH = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_memory_port_if #(.ADDR_W(32)) bus ();

  data_memory_port #(.DEPTH_BYTES(DEPTH), .ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sbq[$];
  logic [7:0]  mdl [DEPTH];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: computes the response and applies stores to mdl.
  task automatic model_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output exp_t e);
    int n;
    longint last;
    logic [31:0] v;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    last = longint'(addr) + n - 1;
    e.err = (size == 2'd3) || (last >= DEPTH);
`ifdef MEM_MISALIGN_TRAP_EN
    if ((size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00)) e.err = 1'b1;
`endif
    e.rdata = 32'h0;
    if (e.err) e.lat = 1;
    else if (int'(addr[1:0]) + n > 4) e.lat = 3;
    else e.lat = 2;
    if (!e.err) begin
      if (we) begin
        for (int i = 0; i < n; i++) mdl[int'(addr) + i] = wdata[8*(n-1-i) +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = {v[23:0], mdl[int'(addr) + i]};
        if (!uns && size == 2'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (!uns && size == 2'd1 && v[15]) v = v | 32'hFFFF_0000;
        e.rdata = v;
      end
    end
  endtask

  // One full transaction; called #1 after a rising edge. hold = cycles to
  // keep rsp_ready low once the response appears.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    exp_t e;
    exp_t got_e;
    int wait_cnt;
    int lat;
    logic [31:0] r0;
    model_req(we, size, uns, addr, wdata, e);
    sbq.push_back(e);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.rsp_ready    = (hold == 0);
    wait_cnt = 0;
    while (!bus.req_ready && wait_cnt < 20) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    check_eq("req_ready_wait", {31'h0, bus.req_ready}, 32'h1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (bus.rsp_valid) break;
    end
    got_e = sbq.pop_front();
    check_eq("rsp_valid", {31'h0, bus.rsp_valid}, 32'h1);
    check_eq("latency", lat, got_e.lat);
    check_eq("rsp_err", {31'h0, bus.rsp_err}, {31'h0, got_e.err});
    check_eq("rsp_rdata", bus.rsp_rdata, got_e.rdata);
    r0 = bus.rsp_rdata;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check_eq("hold_valid", {31'h0, bus.rsp_valid}, 32'h1);
      check_eq("hold_rdata", bus.rsp_rdata, r0);
      check_eq("hold_req_ready", {31'h0, bus.req_ready}, 32'h0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("idle_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check_eq("idle_req_ready", {31'h0, bus.req_ready}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 8'h00;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_req_ready", {31'h0, bus.req_ready}, 32'h0);
    check_eq("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check_eq("rst_rsp_err", {31'h0, bus.rsp_err}, 32'h0);
    check_eq("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_req_ready", {31'h0, bus.req_ready}, 32'h1);

    // Known contents for 0x00..0x3F
    for (int i = 0; i < 16; i++)
      do_req(1'b1, 2'd2, 1'b0, 32'(4*i), 32'hC0DE_0000 + 32'(i * 32'h0101), 0);

    // Word store and sub-word loads
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
    do_req(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 0);
    do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0);

    // Sign/zero extension
    do_req(1'b1, 2'd0, 1'b0, 32'h20, 32'h0000_0080, 0);
    do_req(1'b0, 2'd0, 1'b0, 32'h20, 32'h0, 0);
    do_req(1'b0, 2'd0, 1'b1, 32'h20, 32'h0, 0);
    do_req(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_8001, 0);
    do_req(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 0);
    do_req(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 0);

    // Word-crossing store and its neighbours
    do_req(1'b1, 2'd2, 1'b0, 32'h0E, 32'hAABB_CCDD, 0);
    for (int a = 32'h0D; a <= 32'h12; a++) do_req(1'b0, 2'd0, 1'b1, 32'(a), 32'h0, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h0E, 32'h0, 0);
    do_req(1'b1, 2'd1, 1'b0, 32'h03, 32'h0000_F00D, 0);
    do_req(1'b0, 2'd1, 1'b0, 32'h03, 32'h0, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h05, 32'h0, 0);

    // Errors and range boundary
    do_req(1'b1, 2'd2, 1'b0, 32'(DEPTH - 2), 32'h1234_5678, 0);
    do_req(1'b1, 2'd3, 1'b0, 32'h0, 32'hFFFF_FFFF, 0);
    do_req(1'b0, 2'd0, 1'b0, 32'hFFFF_FFFF, 32'h0, 0);
    do_req(1'b1, 2'd0, 1'b0, 32'hFFFF_FFFF, 32'h55, 0);
    do_req(1'b1, 2'd2, 1'b0, 32'(DEPTH - 4), 32'h8765_4321, 0);
    do_req(1'b0, 2'd0, 1'b0, 32'(DEPTH - 1), 32'h0, 0);
    do_req(1'b0, 2'd1, 1'b0, 32'(DEPTH - 1), 32'h0, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'(DEPTH - 4), 32'h0, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 0);

    // Back-pressure on the response
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5);
    do_req(1'b0, 2'd1, 1'b0, 32'h0F, 32'h0, 5);

    // Random traffic inside the known region
    for (int i = 0; i < 40; i++)
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 60)), $urandom, 0);

    // Reset during the second beat of a split store
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_size = 2'd2;
    bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h2E;
    bus.req_wdata = 32'hDEAD_BEEF;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("abort_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check_eq("abort_req_ready", {31'h0, bus.req_ready}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_idle_ready", {31'h0, bus.req_ready}, 32'h1);
`ifndef MEM_MISALIGN_TRAP_EN
    mdl[32'h2E] = 8'hDE;
    mdl[32'h2F] = 8'hAD;
`endif
    do_req(1'b0, 2'd2, 1'b0, 32'h2C, 32'h0, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
